// File: rtl/mdu_exec_unit_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   mdu_op_e    : 3-bit M-extension operation encoding
//   mdu_state_e : control FSM states
//   is_signed_rs1 / is_signed_rs2 / is_div / is_rem : operation decode helpers
package mdu_exec_unit_pkg;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_signed_rs1(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input mdu_op_e op);
    return op[2] && op[1];
  endfunction

endpackage

// File: rtl/mdu_divider_step.sv
// Combinational restoring-division slice retiring BITS_PER_CYCLE quotient bits.
//   rem/quo/divisor     : current partial remainder, dividend-shifting quotient, divisor
//   rem_nxt/quo_nxt     : values after BITS_PER_CYCLE restoring steps
// The dividend enters through quo MSB-first; quotient bits fill in from the LSB.
module mdu_divider_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] trial;

  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    trial   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      trial   = {rem_nxt, quo_nxt[XLEN-1]};
      quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, divisor}) begin
        trial      = trial - {1'b0, divisor};
        quo_nxt[0] = 1'b1;
      end
      // rem < divisor is invariant, so the restored value always fits XLEN bits
      rem_nxt = trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_exec_unit.sv
// Iterative RV32M multiply/divide execute unit.
//   clk, rst (async active-low), flush (abort current op)
//   in_valid/in_ready/in_op/in_rs1/in_rs2/in_rd_addr/in_pc : request
//   out_valid/out_ready/out_result/out_rd_addr/out_pc       : response
//   busy : unit is not idle
// Shift-add multiply / restoring divide on operand magnitudes, BITS_PER_CYCLE
// bits per cycle, sign fix-up when the result is written on entry to DONE.
// XLEN must be even and >= 8; BITS_PER_CYCLE in {1,2,4} and must divide XLEN.
module mdu_exec_unit
  import mdu_exec_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MDU_OP_WIDTH-1:0] in_op,
  input  logic [XLEN-1:0]         in_rs1,
  input  logic [XLEN-1:0]         in_rs2,
  input  logic [4:0]              in_rd_addr,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_result,
  output logic [4:0]              out_rd_addr,
  output logic [XLEN-1:0]         out_pc,
  output logic                    busy
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state, state_nxt;
  mdu_op_e    op_q, in_op_e;
  logic [CW-1:0]   cnt;
  // MUL: acc_hi = partial product, acc_lo = multiplier, opnd = multiplicand
  // DIV: acc_hi = remainder,       acc_lo = quotient,   opnd = divisor
  logic [XLEN-1:0] acc_hi, acc_lo, opnd;
  logic            neg_q, neg_r;

  logic            fire, s1, s2, fast_zero, fast_ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  assign in_op_e   = mdu_op_e'(in_op);
  assign in_ready  = (state == ST_IDLE) && !flush;
  assign fire      = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign s1        = is_signed_rs1(in_op_e) && in_rs1[XLEN-1];
  assign s2        = is_signed_rs2(in_op_e) && in_rs2[XLEN-1];
  assign mag1      = s1 ? -in_rs1 : in_rs1;
  assign mag2      = s2 ? -in_rs2 : in_rs2;
  assign fast_zero = is_div(in_op_e) && (in_rs2 == '0);
  assign fast_ovf  = is_div(in_op_e) && is_signed_rs1(in_op_e) &&
                     (in_rs1 == INT_MIN) && (in_rs2 == '1);
  assign fast_res  = fast_zero ? (is_rem(in_op_e) ? in_rs1 : '1)
                               : (is_rem(in_op_e) ? '0 : in_rs1);

  // Multiplier step: add-if-lsb then shift the {hi,lo} pair right
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;

  always_comb begin
    mul_hi  = acc_hi;
    mul_lo  = acc_lo;
    mul_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, opnd} : '0);
      mul_lo  = {mul_sum[0], mul_lo[XLEN-1:1]};
      mul_hi  = mul_sum[XLEN:1];
    end
  end

  logic [XLEN-1:0] div_rem, div_quo;

  mdu_divider_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_div_step (
    .rem     (acc_hi),
    .quo     (acc_lo),
    .divisor (opnd),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  // Signed result from the final iteration's outputs
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    prod_fin = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    case (op_q)
      OP_MUL:                        fin_res = prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_res = neg_q ? -div_quo : div_quo;
      default:                       fin_res = neg_r ? -div_rem : div_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fire) begin
        if (!is_div(in_op_e))          state_nxt = ST_MUL;
        else if (fast_zero || fast_ovf) state_nxt = ST_DONE;
        else                            state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= OP_MUL;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_result  <= '0;
      out_rd_addr <= '0;
      out_pc      <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (fire) begin
          op_q        <= in_op_e;
          out_rd_addr <= in_rd_addr;
          out_pc      <= in_pc;
          neg_q       <= s1 ^ s2;
          neg_r       <= s1;
          cnt         <= CW'(ITER - 1);
          acc_hi      <= '0;
          acc_lo      <= is_div(in_op_e) ? mag1 : mag2;
          opnd        <= is_div(in_op_e) ? mag2 : mag1;
          if (fast_zero || fast_ovf) out_result <= fast_res;
        end
        ST_MUL, ST_DIV: begin
          acc_hi <= (state == ST_MUL) ? mul_hi : div_rem;
          acc_lo <= (state == ST_MUL) ? mul_lo : div_quo;
          if (cnt == '0) out_result <= fin_res;
          else           cnt        <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_exec_unit.sv
// Directed self-checking bench: one BITS_PER_CYCLE=1 and one =4 instance share
// the request bus; each has its own in_valid.
module tb_mdu_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0, out_ready = 1'b0, v1 = 1'b0, v4 = 1'b0;
  logic [2:0]  op  = '0;
  logic [31:0] rs1 = '0, rs2 = '0, pc = '0;
  logic [4:0]  rd  = '0;

  logic        rdy1, rdy4, ov1, ov4, busy1, busy4;
  logic [31:0] res1, res4, opc1, opc4;
  logic [4:0]  ord1, ord4;

  int n_total = 0;
  int n_pass  = 0;

  mdu_exec_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v1), .in_ready(rdy1),
    .in_op(op), .in_rs1(rs1), .in_rs2(rs2), .in_rd_addr(rd), .in_pc(pc),
    .out_valid(ov1), .out_ready(out_ready), .out_result(res1),
    .out_rd_addr(ord1), .out_pc(opc1), .busy(busy1)
  );

  mdu_exec_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v4), .in_ready(rdy4),
    .in_op(op), .in_rs1(rs1), .in_rs2(rs2), .in_rd_addr(rd), .in_pc(pc),
    .out_valid(ov4), .out_ready(out_ready), .out_result(res4),
    .out_rd_addr(ord4), .out_pc(opc4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure edges from handshake to out_valid, check the
  // response, optionally stall out_ready for 'hold' cycles, then drain.
  task automatic run_op(input bit s4, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int hold, input string tag);
    int n;
    logic [4:0]  erd;
    logic [31:0] epc;
    erd = {2'b10, o};
    epc = 32'h0000_4000 + {a[15:0], 2'b00};
    op = o; rs1 = a; rs2 = b; rd = erd; pc = epc;
    if (s4) v4 = 1'b1; else v1 = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(s4 ? rdy4 : rdy1), 32'd1);
    tick();
    v1 = 1'b0; v4 = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; rd = 5'd0; pc = '0;
    n = 1;
    while (!(s4 ? ov4 : ov1) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, s4 ? res4 : res1, exp);
    chk({tag, "_rd"}, 32'(s4 ? ord4 : ord1), 32'(erd));
    chk({tag, "_pc"}, s4 ? opc4 : opc1, epc);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(s4 ? ov4 : ov1), 32'd1);
      chk({tag, "_hold_result"}, s4 ? res4 : res1, exp);
      chk({tag, "_hold_in_ready"}, 32'(s4 ? rdy4 : rdy1), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(s4 ? ov4 : ov1), 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (3) tick();
    chk("rst_valid1", 32'(ov1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_result1", res1, 32'd0);
    chk("rst_rd1", 32'(ord1), 32'd0);
    chk("rst_pc1", opc1, 32'd0);
    chk("rst_result4", res4, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_in_ready1", 32'(rdy1), 32'd1);

    // Asynchronous reset in the middle of a division
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (5) tick();
    chk("middiv_busy", 32'(busy1), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("middiv_rst_valid", 32'(ov1), 32'd0);
    chk("middiv_rst_busy", 32'(busy1), 32'd0);
    chk("middiv_rst_result", res1, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Multiply, BPC=1
    run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul_7x-3");
    run_op(1'b0, 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, "mulh");
    run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0, "mulhsu");
    run_op(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33, 0, "mulhu");

    // Division signs, BPC=1 then BPC=4
    run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_-7/2");
    run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_-7/2");
    run_op(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100/7");
    run_op(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100/7");
    run_op(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 9, 0, "b4_div_-7/2");
    run_op(1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 9, 0, "b4_rem_-7/2");
    run_op(1'b1, 3'd5, 32'd100, 32'd7, 32'd14, 9, 0, "b4_divu_100/7");
    run_op(1'b1, 3'd7, 32'd100, 32'd7, 32'd2, 9, 0, "b4_remu_100/7");
    run_op(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 0, "b4_mul_7x-3");

    // Fast paths
    run_op(1'b0, 3'd4, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_by0");
    run_op(1'b0, 3'd6, 32'd5, 32'd0, 32'd5, 1, 0, "rem_by0");
    run_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
    run_op(1'b1, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "b4_divu_by0");

    // Backpressure: 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
    run_op(1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 5, "bp_mulhu");

    // Flush at iteration 10 of a division
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 32'(busy1), 32'd0);
    chk("flush_valid", 32'(ov1), 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (ov1) seen = 1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op(1'b0, 3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "post_flush_remu");

    // Flush together with a request: must not be accepted
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; v1 = 1'b1; flush = 1'b1;
    #1 chk("flushreq_in_ready", 32'(rdy1), 32'd0);
    tick();
    v1 = 1'b0; flush = 1'b0;
    chk("flushreq_busy", 32'(busy1), 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (ov1 || busy1) seen = 1;
    end
    chk("flushreq_ignored", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
